// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : riscv_pkg                                              |
// | Description : Shared encodings and types for the RV32I pipeline:     |
// |               ALU control, result-mux select, forward select, the    |
// |               ID/EX control word and the forward-select helper.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package riscv_pkg;

  // ALU control encodings (3 bits, produced by the ALU decoder)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Result-mux select encodings
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  // Operand forward-select encodings
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Control word carried from decode into execute
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ctrl_e_t;

  // A bubble performs no architectural side effect
  localparam ctrl_e_t CTRL_BUBBLE = '{
    reg_write:   1'b0,
    result_src:  RES_ALU,
    mem_write:   1'b0,
    jump:        1'b0,
    branch:      1'b0,
    alu_control: ALU_ADD,
    alu_src:     1'b0
  };

  // Operand source for one EX source register. x0 is never forwarded,
  // and the younger MEM result wins over the older WB result.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs_e,
    input logic [4:0] rd_m,
    input logic       reg_write_m,
    input logic [4:0] rd_w,
    input logic       reg_write_w
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs_e != 5'd0) begin
      if (reg_write_m && (rd_m == rs_e)) begin
        sel = FWD_MEM;
      end else if (reg_write_w && (rd_w == rs_e)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : hazard_unit                                            |
// | Description : Combinational hazard logic for the ID/EX boundary:     |
// |               load-use stall, branch/jump flush, EX forwarding.      |
// | Ports       : ResultSrcE/RdE/Rs1E/Rs2E - instruction in EX           |
// |               Rs1D/Rs2D                - instruction in ID           |
// |               RdM/RegWriteM, RdW/RegWriteW - MEM and WB writers      |
// |               PCSrcE                   - taken branch/jump in EX     |
// |               lw_stall, flush_e        - internal to the ID/EX reg   |
// |               StallF/StallD/FlushD     - upstream pipeline control   |
// |               ForwardAE/ForwardBE      - EX operand select           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module hazard_unit
  import riscv_pkg::*;
(
  input  logic [1:0] ResultSrcE,
  input  logic [4:0] RdE,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       PCSrcE,
  output logic       lw_stall,
  output logic       flush_e,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE
);

  logic lw_hit;

  always_comb begin
    lw_hit = (ResultSrcE == RES_MEM) && (RdE != 5'd0) &&
             ((RdE == Rs1D) || (RdE == Rs2D));
    // A taken branch squashes the dependent instruction, so no stall
    lw_stall  = lw_hit && !PCSrcE;
    flush_e   = lw_stall || PCSrcE;
    StallF    = lw_stall;
    StallD    = lw_stall;
    FlushD    = PCSrcE;
    ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
    ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : id_ex_stage                                            |
// | Description : ID/EX pipeline register of the five-stage RV32I core   |
// |               with hazard unit and stall/flush event counters.       |
// | Ports       : *D inputs  - decode control word, data, indices        |
// |               *E outputs - registered execute-stage copies           |
// |               PCSrcE, RdM/RdW, RegWriteM/W - downstream hazard info  |
// |               StallF/StallD/FlushD, ForwardAE/BE - hazard outputs    |
// |               stall_cnt/flush_cnt - wrapping event counters          |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic             ALUSrcD,
  input  logic [1:0]       ResultSrcD,
  input  logic [2:0]       AluControlD,
  input  logic [XLEN-1:0]  RD1D,
  input  logic [XLEN-1:0]  RD2D,
  input  logic [XLEN-1:0]  PCD,
  input  logic [XLEN-1:0]  ImmExtD,
  input  logic [XLEN-1:0]  PCPlus4D,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             JumpE,
  output logic             BranchE,
  output logic             ALUSrcE,
  output logic [1:0]       ResultSrcE,
  output logic [2:0]       AluControlE,
  output logic [XLEN-1:0]  RD1E,
  output logic [XLEN-1:0]  RD2E,
  output logic [XLEN-1:0]  PCE,
  output logic [XLEN-1:0]  ImmExtE,
  output logic [XLEN-1:0]  PCPlus4E,
  output logic [4:0]       Rs1E,
  output logic [4:0]       Rs2E,
  output logic [4:0]       RdE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic lw_stall;
  logic flush_e;

  ctrl_e_t          ctrl_d,      ctrl_q;
  logic [XLEN-1:0]  rd1_d,       rd1_q;
  logic [XLEN-1:0]  rd2_d,       rd2_q;
  logic [XLEN-1:0]  pc_d,        pc_q;
  logic [XLEN-1:0]  imm_d,       imm_q;
  logic [XLEN-1:0]  pc4_d,       pc4_q;
  logic [4:0]       rs1_d,       rs1_q;
  logic [4:0]       rs2_d,       rs2_q;
  logic [4:0]       rd_d,        rd_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  hazard_unit u_hazard (
    .ResultSrcE (ctrl_q.result_src),
    .RdE        (rd_q),
    .Rs1E       (rs1_q),
    .Rs2E       (rs2_q),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdM        (RdM),
    .RdW        (RdW),
    .RegWriteM  (RegWriteM),
    .RegWriteW  (RegWriteW),
    .PCSrcE     (PCSrcE),
    .lw_stall   (lw_stall),
    .flush_e    (flush_e),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE)
  );

  always_comb begin
    ctrl_d = '{
      reg_write:   RegWriteD,
      result_src:  ResultSrcD,
      mem_write:   MemWriteD,
      jump:        JumpD,
      branch:      BranchD,
      alu_control: AluControlD,
      alu_src:     ALUSrcD
    };
    rd1_d = RD1D;
    rd2_d = RD2D;
    pc_d  = PCD;
    imm_d = ImmExtD;
    pc4_d = PCPlus4D;
    rs1_d = Rs1D;
    rs2_d = Rs2D;
    rd_d  = RdD;
    // No hold path: a stall or a flush both turn EX into a bubble
    if (flush_e) begin
      ctrl_d = CTRL_BUBBLE;
      rd1_d  = '0;
      rd2_d  = '0;
      pc_d   = '0;
      imm_d  = '0;
      pc4_d  = '0;
      rs1_d  = '0;
      rs2_d  = '0;
      rd_d   = '0;
    end
    stall_cnt_d = stall_cnt_q + CNT_W'(lw_stall);
    flush_cnt_d = flush_cnt_q + CNT_W'(PCSrcE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= CTRL_BUBBLE;
      rd1_q       <= '0;
      rd2_q       <= '0;
      pc_q        <= '0;
      imm_q       <= '0;
      pc4_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      pc_q        <= pc_d;
      imm_q       <= imm_d;
      pc4_q       <= pc4_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign RegWriteE   = ctrl_q.reg_write;
  assign MemWriteE   = ctrl_q.mem_write;
  assign JumpE       = ctrl_q.jump;
  assign BranchE     = ctrl_q.branch;
  assign ALUSrcE     = ctrl_q.alu_src;
  assign ResultSrcE  = ctrl_q.result_src;
  assign AluControlE = ctrl_q.alu_control;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign PCE         = pc_q;
  assign ImmExtE     = imm_q;
  assign PCPlus4E    = pc4_q;
  assign Rs1E        = rs1_q;
  assign Rs2E        = rs2_q;
  assign RdE         = rd_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                         |
// | Description : Self-checking bench for id_ex_stage. Two instances     |
// |               share stimulus: default widths and a 4-bit counter     |
// |               variant. Directed steps followed by random cycles,     |
// |               checked against a cycle-level reference model.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_id_ex_stage;
  import riscv_pkg::*;

  typedef struct packed {
    logic        rw;
    logic        mw;
    logic        jmp;
    logic        br;
    logic        asrc;
    logic [1:0]  res_src;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } e_t;

  logic clk, reset;
  logic RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0] ResultSrcD;
  logic [2:0] AluControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD, RdM, RdW;
  logic PCSrcE, RegWriteM, RegWriteW;

  logic RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0] ResultSrcE;
  logic [2:0] AluControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic StallF, StallD, FlushD;
  logic [1:0] ForwardAE, ForwardBE;
  logic [31:0] stall_cnt, flush_cnt;

  logic RegWriteE4, MemWriteE4, JumpE4, BranchE4, ALUSrcE4;
  logic [1:0] ResultSrcE4;
  logic [2:0] AluControlE4;
  logic [31:0] RD1E4, RD2E4, PCE4, ImmExtE4, PCPlus4E4;
  logic [4:0] Rs1E4, Rs2E4, RdE4;
  logic StallF4, StallD4, FlushD4;
  logic [1:0] ForwardAE4, ForwardBE4;
  logic [3:0] stall_cnt4, flush_cnt4;

  id_ex_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .AluControlD(AluControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE),
    .AluControlE(AluControlE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE),
    .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .RdE(RdE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(4)) dut_w4 (
    .clk(clk), .reset(reset),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
    .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD),
    .AluControlD(AluControlD), .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD),
    .ImmExtD(ImmExtD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .PCSrcE(PCSrcE), .RdM(RdM), .RdW(RdW),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RegWriteE(RegWriteE4), .MemWriteE(MemWriteE4), .JumpE(JumpE4),
    .BranchE(BranchE4), .ALUSrcE(ALUSrcE4), .ResultSrcE(ResultSrcE4),
    .AluControlE(AluControlE4), .RD1E(RD1E4), .RD2E(RD2E4), .PCE(PCE4),
    .ImmExtE(ImmExtE4), .PCPlus4E(PCPlus4E4), .Rs1E(Rs1E4), .Rs2E(Rs2E4),
    .RdE(RdE4), .StallF(StallF4), .StallD(StallD4), .FlushD(FlushD4),
    .ForwardAE(ForwardAE4), .ForwardBE(ForwardBE4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state
  e_t          m_e;
  logic [31:0] m_stall, m_flush;
  logic [3:0]  m_stall4, m_flush4;

  logic [2:0] alu_ops [5];

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic e_t d_word();
    e_t w;
    w = {RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, AluControlD,
         RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD};
    return w;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (src == 5'd0) return 2'd0;
    if (RegWriteM && RdM == src) return 2'd2;
    if (RegWriteW && RdW == src) return 2'd1;
    return 2'd0;
  endfunction

  // {StallF, StallD, FlushD, ForwardAE, ForwardBE}
  function automatic logic [6:0] model_comb();
    logic hit, stall;
    hit   = (m_e.res_src == 2'b01) && (m_e.rd != 5'd0) &&
            ((m_e.rd == Rs1D) || (m_e.rd == Rs2D));
    stall = hit && !PCSrcE;
    return {stall, stall, PCSrcE, model_fwd(m_e.rs1), model_fwd(m_e.rs2)};
  endfunction

  function automatic e_t dut_bus();
    e_t w;
    w = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, AluControlE,
         RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE};
    return w;
  endfunction

  function automatic e_t dut4_bus();
    e_t w;
    w = {RegWriteE4, MemWriteE4, JumpE4, BranchE4, ALUSrcE4, ResultSrcE4, AluControlE4,
         RD1E4, RD2E4, PCE4, ImmExtE4, PCPlus4E4, Rs1E4, Rs2E4, RdE4};
    return w;
  endfunction

  // Check combinational outputs, advance one edge, check registered state.
  task automatic tick();
    logic [6:0] c;
    logic       stall;
    #1;
    c = model_comb();
    check("comb", {185'd0, StallF, StallD, FlushD, ForwardAE, ForwardBE}, {185'd0, c});
    check("comb_w4", {185'd0, StallF4, StallD4, FlushD4, ForwardAE4, ForwardBE4}, {185'd0, c});
    stall = c[6];
    if (reset) begin
      m_e = '0; m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
    end else begin
      m_e = (stall || PCSrcE) ? e_t'('0) : d_word();
      m_stall  = m_stall  + (stall ? 32'd1 : 32'd0);
      m_flush  = m_flush  + (PCSrcE ? 32'd1 : 32'd0);
      m_stall4 = m_stall4 + (stall ? 4'd1 : 4'd0);
      m_flush4 = m_flush4 + (PCSrcE ? 4'd1 : 4'd0);
    end
    @(posedge clk);
    #1;
    check("e_regs", {7'd0, dut_bus()}, {7'd0, m_e});
    check("e_regs_w4", {7'd0, dut4_bus()}, {7'd0, m_e});
    check("stall_cnt", {160'd0, stall_cnt}, {160'd0, m_stall});
    check("flush_cnt", {160'd0, flush_cnt}, {160'd0, m_flush});
    check("stall_cnt_w4", {188'd0, stall_cnt4}, {188'd0, m_stall4});
    check("flush_cnt_w4", {188'd0, flush_cnt4}, {188'd0, m_flush4});
  endtask

  task automatic clear_inputs();
    RegWriteD = 0; MemWriteD = 0; JumpD = 0; BranchD = 0; ALUSrcD = 0;
    ResultSrcD = 2'b00; AluControlD = 3'b000;
    RD1D = '0; RD2D = '0; PCD = '0; ImmExtD = '0; PCPlus4D = '0;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    PCSrcE = 0; RdM = '0; RdW = '0; RegWriteM = 0; RegWriteW = 0;
  endtask

  task automatic random_inputs();
    RegWriteD   = 1'($urandom_range(0, 1));
    MemWriteD   = 1'($urandom_range(0, 1));
    JumpD       = 1'($urandom_range(0, 1));
    BranchD     = 1'($urandom_range(0, 1));
    ALUSrcD     = 1'($urandom_range(0, 1));
    ResultSrcD  = 2'($urandom_range(0, 2));
    AluControlD = alu_ops[$urandom_range(0, 4)];
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom;
    ImmExtD = $urandom; PCPlus4D = $urandom;
    // Small index range so hazards occur often
    Rs1D = 5'($urandom_range(0, 3));
    Rs2D = 5'($urandom_range(0, 3));
    RdD  = 5'($urandom_range(0, 3));
    RdM  = 5'($urandom_range(0, 3));
    RdW  = 5'($urandom_range(0, 3));
    RegWriteM = 1'($urandom_range(0, 1));
    RegWriteW = 1'($urandom_range(0, 1));
    PCSrcE = ($urandom_range(0, 4) == 0);
    reset  = ($urandom_range(0, 39) == 0);
  endtask

  initial begin
    logic [3:0] base4;
    alu_ops[0] = ALU_ADD; alu_ops[1] = ALU_SUB; alu_ops[2] = ALU_AND;
    alu_ops[3] = ALU_OR;  alu_ops[4] = ALU_SLT;

    // Reset with nonzero decode inputs
    clear_inputs();
    RegWriteD = 1; MemWriteD = 1; JumpD = 1; BranchD = 1; ALUSrcD = 1;
    ResultSrcD = 2'b01; AluControlD = 3'b101;
    RD1D = 32'hdead_beef; RD2D = 32'h1234_5678; PCD = 32'h100;
    ImmExtD = 32'h44; PCPlus4D = 32'h104; Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3;
    reset = 1;
    @(posedge clk);
    #1;
    m_e = '0; m_stall = '0; m_flush = '0; m_stall4 = '0; m_flush4 = '0;
    tick();
    tick();
    check("rst_alu", {189'd0, AluControlE}, 192'd0);
    check("rst_regwrite", {191'd0, RegWriteE}, 192'd0);
    check("rst_stallf", {191'd0, StallF}, 192'd0);
    check("rst_flushd", {191'd0, FlushD}, 192'd0);

    // Pass-through
    reset = 0;
    clear_inputs();
    AluControlD = 3'b101; RD1D = 32'h10; RdD = 5'd3; RegWriteD = 1;
    tick();
    check("pt_alu", {189'd0, AluControlE}, {189'd0, 3'b101});
    check("pt_rd1", {160'd0, RD1E}, {160'd0, 32'h10});
    check("pt_rd", {187'd0, RdE}, {187'd0, 5'd3});
    check("pt_regwrite", {191'd0, RegWriteE}, {191'd0, 1'b1});

    // Load-use stall: lw x5 in EX, consumer of x5 in ID
    clear_inputs();
    ResultSrcD = 2'b01; RdD = 5'd5; RegWriteD = 1;
    tick();
    clear_inputs();
    Rs1D = 5'd5; RegWriteD = 1; MemWriteD = 1; RdD = 5'd6;
    #1;
    check("lu_stallf", {191'd0, StallF}, {191'd0, 1'b1});
    check("lu_stalld", {191'd0, StallD}, {191'd0, 1'b1});
    tick();
    check("lu_bubble_rw", {191'd0, RegWriteE}, 192'd0);
    check("lu_bubble_mw", {191'd0, MemWriteE}, 192'd0);
    check("lu_stall_cnt", {160'd0, stall_cnt}, {160'd0, 32'd1});

    // Load into x0 never stalls
    clear_inputs();
    ResultSrcD = 2'b01; RdD = 5'd0;
    tick();
    clear_inputs();
    #1;
    check("lu_x0_nostall", {191'd0, StallF}, 192'd0);
    tick();

    // Forwarding with Rs1E = Rs2E = 7
    clear_inputs();
    Rs1D = 5'd7; Rs2D = 5'd7;
    tick();
    RdM = 5'd7; RegWriteM = 1; RdW = 5'd7; RegWriteW = 1;
    #1;
    check("fwdA_mem", {190'd0, ForwardAE}, {190'd0, 2'b10});
    check("fwdB_mem", {190'd0, ForwardBE}, {190'd0, 2'b10});
    RegWriteM = 0;
    #1;
    check("fwdA_wb", {190'd0, ForwardAE}, {190'd0, 2'b01});
    check("fwdB_wb", {190'd0, ForwardBE}, {190'd0, 2'b01});
    clear_inputs();
    tick();
    RdM = 5'd0; RegWriteM = 1; RdW = 5'd0; RegWriteW = 1;
    #1;
    check("fwdA_x0", {190'd0, ForwardAE}, 192'd0);
    check("fwdB_x0", {190'd0, ForwardBE}, 192'd0);

    // Branch flush
    clear_inputs();
    RegWriteD = 1; MemWriteD = 1; RdD = 5'd9; ResultSrcD = 2'b01; PCSrcE = 1;
    #1;
    check("br_flushd", {191'd0, FlushD}, {191'd0, 1'b1});
    tick();
    check("br_bubble_rw", {191'd0, RegWriteE}, 192'd0);
    check("br_flush_cnt", {160'd0, flush_cnt}, {160'd0, 32'd1});

    // Branch and load-use hit together: branch wins
    clear_inputs();
    ResultSrcD = 2'b01; RdD = 5'd5; RegWriteD = 1;
    tick();
    clear_inputs();
    Rs1D = 5'd5; PCSrcE = 1;
    #1;
    check("brlu_stallf", {191'd0, StallF}, 192'd0);
    check("brlu_flushd", {191'd0, FlushD}, {191'd0, 1'b1});
    tick();
    check("brlu_stall_cnt", {160'd0, stall_cnt}, {160'd0, 32'd1});
    check("brlu_flush_cnt", {160'd0, flush_cnt}, {160'd0, 32'd2});

    // 4-bit flush counter wraps after 16 flushes
    clear_inputs();
    PCSrcE = 1;
    base4 = m_flush4;
    for (int i = 0; i < 16; i++) tick();
    check("wrap_flush_cnt4", {188'd0, flush_cnt4}, {188'd0, 4'd2});
    check("wrap_model_base", {188'd0, flush_cnt4}, {188'd0, base4});
    check("wrap_flush_cnt32", {160'd0, flush_cnt}, {160'd0, 32'd18});

    // Random traffic including mid-run resets
    for (int i = 0; i < 300; i++) begin
      random_inputs();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
